// File: rtl/mont_exp_ctrl_if.sv
// Multiplier-side bus of the modular exponentiation sequencer: start/done
// handshake, held operands and returned product.
interface mont_exp_ctrl_if #(
    parameter int WIDTH = 1024
);
    logic             mul_start;
    logic [WIDTH-1:0] mul_a;
    logic [WIDTH-1:0] mul_b;
    logic [WIDTH-1:0] mul_m;
    logic [WIDTH-1:0] mul_result;
    logic             mul_done;

    // Sequencer side: launches products and consumes results
    modport master (
        output mul_start, mul_a, mul_b, mul_m,
        input  mul_result, mul_done
    );

    // Multiplier side
    modport slave (
        input  mul_start, mul_a, mul_b, mul_m,
        output mul_result, mul_done
    );
endinterface

// File: rtl/mont_exp_ctrl.sv
// Left-to-right square-and-multiply sequencer computing X^E mod M in
// Montgomery form through an external Montgomery multiplier.
module mont_exp_ctrl #(
    parameter int WIDTH = 1024,
    parameter int EXP_W = 1024,
    parameter int LEN_W = 11
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     in_x,
    input  logic [EXP_W-1:0]     in_e,
    input  logic [LEN_W-1:0]     in_e_len,
    input  logic [WIDTH-1:0]     in_m,
    input  logic [WIDTH-1:0]     in_r,
    input  logic [WIDTH-1:0]     in_r2,
    mont_exp_ctrl_if.master      mul,
    output logic [WIDTH-1:0]     result,
    output logic                 done,
    output logic                 busy
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_PRE_I,  S_PRE_W,
        S_SQ_I,   S_SQ_W,
        S_MUL_I,  S_MUL_W,
        S_NEXT,
        S_POST_I, S_POST_W,
        S_FIN
    } state_t;

    state_t           r_state;
    state_t           w_next;

    logic [WIDTH-1:0] r_x;
    logic [EXP_W-1:0] r_e;
    logic [LEN_W-1:0] r_len;
    logic [LEN_W-1:0] r_idx;
    logic [WIDTH-1:0] r_m;
    logic [WIDTH-1:0] r_r2;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_xm;
    logic [WIDTH-1:0] r_result;

    logic [LEN_W-1:0] w_len;
    logic             w_ebit;

    // Lengths beyond the exponent register saturate to its full width
    assign w_len  = (in_e_len > LEN_W'(EXP_W)) ? LEN_W'(EXP_W) : in_e_len;
    // Mask-and-reduce keeps the bit select width-agnostic w.r.t. LEN_W
    assign w_ebit = |(r_e & (EXP_W'(1) << r_idx));

    // State register
    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // Next-state selection; products advance only on mul_done in a WAIT state
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:   if (start) w_next = S_PRE_I;
            S_PRE_I:  w_next = S_PRE_W;
            S_PRE_W:  if (mul.mul_done) w_next = (r_len == '0) ? S_POST_I : S_SQ_I;
            S_SQ_I:   w_next = S_SQ_W;
            S_SQ_W:   if (mul.mul_done) w_next = w_ebit ? S_MUL_I : S_NEXT;
            S_MUL_I:  w_next = S_MUL_W;
            S_MUL_W:  if (mul.mul_done) w_next = S_NEXT;
            S_NEXT:   w_next = (r_idx == '0) ? S_POST_I : S_SQ_I;
            S_POST_I: w_next = S_POST_W;
            S_POST_W: if (mul.mul_done) w_next = S_FIN;
            S_FIN:    w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // Operand latch, product write-back and bit-index walk
    always_ff @(posedge clk) begin
        if (reset) begin
            r_x      <= '0;
            r_e      <= '0;
            r_len    <= '0;
            r_idx    <= '0;
            r_m      <= '0;
            r_r2     <= '0;
            r_acc    <= '0;
            r_xm     <= '0;
            r_result <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: if (start) begin
                    r_x   <= in_x;
                    r_e   <= in_e;
                    r_len <= w_len;
                    r_idx <= w_len - LEN_W'(1);
                    r_m   <= in_m;
                    r_r2  <= in_r2;
                    r_acc <= in_r;
                end
                S_PRE_W:          if (mul.mul_done) r_xm     <= mul.mul_result;
                S_SQ_W, S_MUL_W:  if (mul.mul_done) r_acc    <= mul.mul_result;
                S_POST_W:         if (mul.mul_done) r_result <= mul.mul_result;
                S_NEXT:           if (r_idx != '0)  r_idx    <= r_idx - LEN_W'(1);
                default: ;
            endcase
        end
    end

    // Outputs decoded from state; operands come straight from held registers
    always_comb begin
        mul.mul_start = 1'b0;
        mul.mul_a     = '0;
        mul.mul_b     = '0;
        mul.mul_m     = r_m;
        done          = 1'b0;
        busy          = (r_state != S_IDLE) && (r_state != S_FIN);
        result        = r_result;
        unique case (r_state)
            S_PRE_I, S_PRE_W: begin
                mul.mul_a = r_x;
                mul.mul_b = r_r2;
            end
            S_SQ_I, S_SQ_W: begin
                mul.mul_a = r_acc;
                mul.mul_b = r_acc;
            end
            S_MUL_I, S_MUL_W: begin
                mul.mul_a = r_acc;
                mul.mul_b = r_xm;
            end
            S_POST_I, S_POST_W: begin
                mul.mul_a = r_acc;
                mul.mul_b = WIDTH'(1);
            end
            S_FIN:   done = 1'b1;
            default: ;
        endcase
        mul.mul_start = (r_state == S_PRE_I) || (r_state == S_SQ_I) ||
                        (r_state == S_MUL_I) || (r_state == S_POST_I);
    end

endmodule

// File: tb/tb_mont_exp_ctrl.sv
// Directed and random checks of mont_exp_ctrl with a behavioural Montgomery
// multiplier of random latency.
`define CHK(TAG, OBS, EXP) \
    begin \
        n_assert++; \
        assert ((OBS) === (EXP)) else begin \
            n_fail++; \
            $error("FAIL %s: observed %0h expected %0h", TAG, OBS, EXP); \
        end \
    end

module tb_mont_exp_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  in_x, in_m, in_r, in_r2;
    logic [15:0] in_e;
    logic [4:0]  in_e_len;
    logic [7:0]  result;
    logic        done, busy;

    int n_assert = 0;
    int n_fail   = 0;

    // multiplier model state
    int          n_pulses = 0;
    int          hs_err   = 0;
    int          lat_max  = 20;
    bit          pending  = 1'b0;
    int          cnt      = 0;
    logic [7:0]  cap_a, cap_b, cap_m;
    logic [7:0]  m_res    = '0;
    logic        m_done   = 1'b0;
    logic        inj_en   = 1'b0;
    logic        idle_done = 1'b0;
    logic [7:0]  cur_m    = '0;

    mont_exp_ctrl_if #(.WIDTH(8)) mul_if ();

    assign mul_if.mul_result = m_res;
    assign mul_if.mul_done   = m_done | (inj_en & mul_if.mul_start) | idle_done;

    mont_exp_ctrl #(.WIDTH(8), .EXP_W(16), .LEN_W(5)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .in_x     (in_x),
        .in_e     (in_e),
        .in_e_len (in_e_len),
        .in_m     (in_m),
        .in_r     (in_r),
        .in_r2    (in_r2),
        .mul      (mul_if),
        .result   (result),
        .done     (done),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    function automatic int mont(input int a, input int b, input int m);
        int t = a * b;
        for (int k = 0; k < 8; k++) begin
            if (t % 2 == 1) t = t + m;
            t = t / 2;
        end
        if (t >= m) t = t - m;
        return t;
    endfunction

    function automatic int ref_exp(input int x, input int e, input int len, input int m);
        int a = 1 % m;
        for (int i = len - 1; i >= 0; i--) begin
            a = (a * a) % m;
            if (e[i]) a = (a * x) % m;
        end
        return a;
    endfunction

    function automatic int ref_prods(input int e, input int len);
        int p = 2 + len;
        for (int i = 0; i < len; i++) if (e[i]) p++;
        return p;
    endfunction

    // Behavioural multiplier: latches operands on mul_start, answers after
    // a random delay, and flags operand instability or overlapping launches
    always @(negedge clk) begin
        m_done = 1'b0;
        if (reset) begin
            pending = 1'b0;
        end else begin
            if (mul_if.mul_start) n_pulses++;
            if (pending) begin
                if (mul_if.mul_a !== cap_a || mul_if.mul_b !== cap_b || mul_if.mul_m !== cap_m) hs_err++;
                if (mul_if.mul_start) hs_err++;
                cnt--;
                if (cnt == 0) begin
                    m_res   = 8'(mont(int'(cap_a), int'(cap_b), int'(cap_m)));
                    m_done  = 1'b1;
                    pending = 1'b0;
                end
            end else if (mul_if.mul_start) begin
                cap_a = mul_if.mul_a;
                cap_b = mul_if.mul_b;
                cap_m = mul_if.mul_m;
                if (cap_m !== cur_m) hs_err++;
                cnt     = int'($urandom_range(1, lat_max));
                pending = 1'b1;
            end
        end
    end

    task automatic drive_op(input int x, input int e, input int len, input int m);
        in_x     = 8'(x);
        in_e     = 16'(e);
        in_e_len = 5'(len);
        in_m     = 8'(m);
        in_r     = 8'(256 % m);
        in_r2    = 8'(65536 % m);
        cur_m    = 8'(m);
    endtask

    task automatic run_op(input int x, input int e, input int len, input int m,
                          input bit noise, input string tag);
        int  leff  = (len > 16) ? 16 : len;
        int  exp_r = ref_exp(x, e, leff, m);
        int  exp_p = ref_prods(e, leff);
        int  base_p, base_h, busy_err;
        bit  seen  = 1'b0;
        @(negedge clk);
        drive_op(x, e, len, m);
        start  = 1'b1;
        base_p = n_pulses;
        base_h = hs_err;
        busy_err = 0;
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if (done === 1'b1) begin
                seen = 1'b1;
                break;
            end
            if (busy !== 1'b1) busy_err++;
            if (noise && (cyc % 5 == 2)) begin
                start    = 1'b1;
                in_x     = 8'($urandom);
                in_e     = 16'($urandom);
                in_e_len = 5'($urandom);
                in_m     = 8'($urandom);
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        `CHK({tag, "_done_seen"}, seen, 1'b1)
        `CHK({tag, "_result"}, int'(result), exp_r)
        `CHK({tag, "_busy_at_done"}, busy, 1'b0)
        `CHK({tag, "_busy_during"}, busy_err, 0)
        `CHK({tag, "_products"}, n_pulses - base_p, exp_p)
        `CHK({tag, "_handshake"}, hs_err - base_h, 0)
        // a start presented in the FIN cycle must not be taken
        start = noise;
        @(negedge clk);
        `CHK({tag, "_done_one_cycle"}, done, 1'b0)
        if (noise) `CHK({tag, "_fin_start_ignored"}, busy, 1'b0)
        start = 1'b0;
    endtask

    initial begin
        int sc;
        reset = 1'b1;
        start = 1'b0;
        drive_op(0, 0, 0, 181);
        repeat (3) @(negedge clk);
        `CHK("reset_busy", busy, 1'b0)
        `CHK("reset_done", done, 1'b0)
        `CHK("reset_result", result, 8'h00)
        `CHK("reset_mul_start", mul_if.mul_start, 1'b0)
        `CHK("reset_mul_a", mul_if.mul_a, 8'h00)
        `CHK("reset_mul_b", mul_if.mul_b, 8'h00)
        reset = 1'b0;
        @(negedge clk);

        // stray completion pulse while idle
        idle_done = 1'b1;
        @(negedge clk);
        idle_done = 1'b0;
        @(negedge clk);
        `CHK("idle_done_busy", busy, 1'b0)
        `CHK("idle_done_done", done, 1'b0)
        `CHK("idle_done_result", result, 8'h00)

        run_op(3, 16'h000D, 4, 181, 1'b0, "basic");
        `CHK("basic_value", result, 8'd75)
        run_op(3, 16'hFFFF, 0, 181, 1'b0, "len0");
        `CHK("len0_value", result, 8'd1)
        run_op(100, 16'h0001, 1, 181, 1'b0, "e1");
        `CHK("e1_value", result, 8'd100)
        run_op(100, 16'h0002, 1, 181, 1'b0, "e2len1");
        `CHK("e2len1_value", result, 8'd1)
        run_op(3, 16'h0003, 20, 181, 1'b0, "clamp");
        `CHK("clamp_value", result, 8'd27)

        // busy-time start pulses, shifting inputs and spurious done in ISSUE
        inj_en = 1'b1;
        run_op(3, 16'h000D, 4, 181, 1'b1, "noisy");
        inj_en = 1'b0;
        `CHK("noisy_value", result, 8'd75)
        idle_done = 1'b1;
        @(negedge clk);
        idle_done = 1'b0;
        @(negedge clk);
        `CHK("idle_done2_result", result, 8'd75)
        `CHK("idle_done2_busy", busy, 1'b0)

        // reset in the WAIT of the fifth product
        drive_op(3, 16'h000D, 4, 181);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        sc = 0;
        for (int cyc = 0; cyc < 2000 && sc < 5; cyc++) begin
            if (mul_if.mul_start === 1'b1) sc++;
            if (sc < 5) @(negedge clk);
        end
        `CHK("abort_reached_5th", sc, 5)
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        `CHK("abort_busy", busy, 1'b0)
        `CHK("abort_done", done, 1'b0)
        `CHK("abort_result", result, 8'h00)
        `CHK("abort_mul_start", mul_if.mul_start, 1'b0)
        @(negedge clk);
        `CHK("abort_done_later", done, 1'b0)
        reset = 1'b0;
        run_op(3, 16'h000D, 4, 181, 1'b0, "after_abort");
        `CHK("after_abort_value", result, 8'd75)

        // random sweep with short multiplier latency
        lat_max = 4;
        for (int k = 0; k < 500; k++) begin
            int m = 2 * int'($urandom_range(1, 127)) + 1;
            int x = int'($urandom_range(0, m - 1));
            int e = int'($urandom_range(0, 65535));
            int l = int'($urandom_range(0, 16));
            run_op(x, e, l, m, 1'b0, "sweep");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
